// File: rtl/rx_pkt_reader.sv
// Read-side sequencer for the MAC Rx packet buffer: parses headers, streams
// payload words on a valid/ready port and releases buffer space to the writer.
module rx_pkt_reader #(
   parameter int ADDR_W    = 9,
   parameter int MAX_WORDS = 1200
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W:0]   commited_wr_address,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [63:0]       rd_data,
   output logic [ADDR_W:0]   rd_addr_extended,
   input  logic              enable,
   output logic [63:0]       pkt_data,
   output logic [7:0]        pkt_keep,
   output logic              pkt_sof,
   output logic              pkt_eof,
   output logic [15:0]       pkt_len,
   output logic              pkt_valid,
   input  logic              pkt_ready,
   output logic [31:0]       pkt_count,
   output logic [15:0]       corrupt_count
);

   localparam int PW = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      HDR_WAIT,
      HDR_CAP,
      STREAM,
      RELEASE,
      CORRUPT
   } state_t;

   state_t            state_q;
   logic [PW-1:0]     s0_q;
   logic [PW-1:0]     s1_q;
   logic [PW-1:0]     c_q;
   logic [PW-1:0]     head_q;
   logic [PW-1:0]     ext_q;
   logic [PW-1:0]     rptr_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [15:0]       nwords_q;
   logic [15:0]       left_q;
   logic [15:0]       beat_q;
   logic [15:0]       len_q;
   logic [7:0]        lkeep_q;
   logic              req_q;
   logic              vld_q;
   logic [63:0]       fifo_q [4];
   logic [1:0]        wp_q;
   logic [1:0]        rp_q;
   logic [2:0]        cnt_q;
   logic [31:0]       pcnt_q;
   logic [15:0]       ccnt_q;

   logic [31:0]   hdr_bytes;
   logic [32:0]   hdr_words;
   logic [PW-1:0] avail;
   logic          hdr_bad;
   logic [2:0]    rem;
   logic [7:0]    keep_last;
   logic [3:0]    occ;
   logic          issue;
   logic          valid;
   logic          pop;
   logic          push;
   logic          last_beat;
   logic [PW-1:0] next_hdr;

   assign hdr_bytes = rd_data[63:32];
   assign hdr_words = ({1'b0, hdr_bytes} + 33'd7) >> 3;
   assign avail     = c_q - head_q - PW'(1);
   assign hdr_bad   = (hdr_bytes == 32'd0)
                   || (hdr_words > 33'(MAX_WORDS))
                   || (hdr_words > 33'(avail));
   assign rem       = hdr_bytes[2:0];
   assign keep_last = (rem == 3'd0) ? 8'hFF : ~(8'hFF << rem);

   // Reads in flight plus stored words never exceed the four entries,
   // which still lets the two-cycle read pipeline run at one word per clock.
   assign occ   = {1'b0, cnt_q} + {3'b0, vld_q} + {3'b0, req_q};
   assign issue = (state_q == STREAM) && (left_q != 16'd0) && (occ < 4'd4);

   assign valid     = (state_q == STREAM) && (cnt_q != 3'd0);
   assign pop       = valid && pkt_ready;
   assign push      = vld_q;
   assign last_beat = (beat_q == nwords_q - 16'd1);
   assign next_hdr  = head_q + nwords_q[PW-1:0] + PW'(1);

   assign pkt_valid        = valid;
   assign pkt_data         = valid ? fifo_q[rp_q] : 64'd0;
   assign pkt_sof          = valid && (beat_q == 16'd0);
   assign pkt_eof          = valid && last_beat;
   assign pkt_keep         = !valid ? 8'h00 : (last_beat ? lkeep_q : 8'hFF);
   assign pkt_len          = len_q;
   assign rd_addr          = rd_addr_q;
   assign rd_addr_extended = ext_q;
   assign pkt_count        = pcnt_q;
   assign corrupt_count    = ccnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         s0_q      <= '0;
         s1_q      <= '0;
         c_q       <= '0;
         head_q    <= '0;
         ext_q     <= '0;
         rptr_q    <= '0;
         rd_addr_q <= '0;
         nwords_q  <= '0;
         left_q    <= '0;
         beat_q    <= '0;
         len_q     <= '0;
         lkeep_q   <= '0;
         req_q     <= 1'b0;
         vld_q     <= 1'b0;
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
         wp_q      <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
         pcnt_q    <= '0;
         ccnt_q    <= '0;
      end else begin
         s0_q <= commited_wr_address;
         s1_q <= s0_q;
         if (s0_q == s1_q) c_q <= s1_q;

         req_q <= issue;
         vld_q <= req_q;
         if (issue) begin
            rd_addr_q <= rptr_q[ADDR_W-1:0];
            rptr_q    <= rptr_q + PW'(1);
            left_q    <= left_q - 16'd1;
         end

         if (push) begin
            fifo_q[wp_q] <= rd_data;
            wp_q         <= wp_q + 2'd1;
         end
         if (pop) begin
            rp_q   <= rp_q + 2'd1;
            beat_q <= beat_q + 16'd1;
         end
         cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};

         unique case (state_q)
            IDLE: begin
               if (enable && (c_q != head_q)) begin
                  rd_addr_q <= head_q[ADDR_W-1:0];
                  state_q   <= HDR_WAIT;
               end
            end
            HDR_WAIT: state_q <= HDR_CAP;
            HDR_CAP: begin
               if (hdr_bad) begin
                  state_q <= CORRUPT;
               end else begin
                  rptr_q   <= head_q + PW'(1);
                  left_q   <= hdr_words[15:0];
                  nwords_q <= hdr_words[15:0];
                  beat_q   <= '0;
                  len_q    <= hdr_bytes[15:0];
                  lkeep_q  <= keep_last;
                  state_q  <= STREAM;
               end
            end
            STREAM: begin
               if (pop && last_beat) state_q <= RELEASE;
            end
            RELEASE: begin
               ext_q   <= next_hdr;
               head_q  <= next_hdr;
               pcnt_q  <= pcnt_q + 32'd1;
               state_q <= IDLE;
            end
            CORRUPT: begin
               head_q <= c_q;
               ext_q  <= c_q;
               if (ccnt_q != 16'hFFFF) ccnt_q <= ccnt_q + 16'd1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_pkt_reader.sv
// Directed bench for rx_pkt_reader: BRAM model, packet collector with
// hand-computed expectations for data order, flags, pointers and counters.
module tb_rx_pkt_reader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  commited_wr_address = '0;
   logic [8:0]  rd_addr;
   logic [63:0] rd_data;
   logic [9:0]  rd_addr_extended;
   logic        enable = 1'b1;
   logic [63:0] pkt_data;
   logic [7:0]  pkt_keep;
   logic        pkt_sof;
   logic        pkt_eof;
   logic [15:0] pkt_len;
   logic        pkt_valid;
   logic        pkt_ready = 1'b1;
   logic [31:0] pkt_count;
   logic [15:0] corrupt_count;

   logic [63:0] mem [512];
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   rx_pkt_reader dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .commited_wr_address (commited_wr_address),
      .rd_addr             (rd_addr),
      .rd_data             (rd_data),
      .rd_addr_extended    (rd_addr_extended),
      .enable              (enable),
      .pkt_data            (pkt_data),
      .pkt_keep            (pkt_keep),
      .pkt_sof             (pkt_sof),
      .pkt_eof             (pkt_eof),
      .pkt_len             (pkt_len),
      .pkt_valid           (pkt_valid),
      .pkt_ready           (pkt_ready),
      .pkt_count           (pkt_count),
      .corrupt_count       (corrupt_count)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic put_hdr(input int h, input int bytes);
      mem[h % 512] = {32'(bytes), 32'h0};
   endtask

   function automatic logic [63:0] word(input int h, input int i,
                                        input int id);
      return {16'hA5C3, 16'(id), 16'(i), 16'((h + i) % 512)};
   endfunction

   task automatic put_pkt(input int h, input int bytes, input int id);
      int n;
      n = (bytes + 7) / 8;
      put_hdr(h, bytes);
      for (int i = 1; i <= n; i++) mem[(h + i) % 512] = word(h, i, id);
   endtask

   task automatic get_pkt(input int h, input int bytes, input int id,
                          input bit rnd);
      int n, beat, t, rem;
      logic [7:0] kexp;
      logic stalled;
      logic [63:0] sd;
      logic [9:0] sf;
      n = (bytes + 7) / 8;
      rem = bytes % 8;
      kexp = (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
      beat = 0;
      t = 0;
      stalled = 1'b0;
      sd = '0;
      sf = '0;
      while (beat < n && t < 4000) begin
         @(negedge clk);
         t++;
         if (stalled) begin
            chk("stall_valid", pkt_valid, 1'b1);
            chk("stall_data", pkt_data, sd);
            chk("stall_flags", {pkt_sof, pkt_eof, pkt_keep}, sf);
         end
         pkt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         stalled = pkt_valid && !pkt_ready;
         sd = pkt_data;
         sf = {pkt_sof, pkt_eof, pkt_keep};
         if (pkt_valid && pkt_ready) begin
            chk("data", pkt_data, word(h, beat + 1, id));
            chk("sof", pkt_sof, beat == 0);
            chk("eof", pkt_eof, beat == n - 1);
            chk("keep", pkt_keep, (beat == n - 1) ? kexp : 8'hFF);
            chk("len", pkt_len, 16'(bytes));
            beat++;
         end
      end
      pkt_ready = 1'b1;
      chk("beats", beat, n);
   endtask

   task automatic idle_check(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (pkt_valid) seen = 1'b1;
      end
      chk(tag, seen, 1'b0);
   endtask

   initial begin
      logic seen;
      for (int i = 0; i < 512; i++) mem[i] = '0;
      cycles(3);
      chk("rst_ext", rd_addr_extended, 10'd0);
      chk("rst_valid", pkt_valid, 1'b0);
      chk("rst_pcnt", pkt_count, 32'd0);
      chk("rst_ccnt", corrupt_count, 16'd0);
      chk("rst_rdaddr", rd_addr, 9'd0);
      reset_n = 1'b1;
      cycles(2);

      put_pkt(0, 64, 1);
      commited_wr_address = 10'd9;
      get_pkt(0, 64, 1, 1'b0);
      cycles(4);
      chk("t1_ext", rd_addr_extended, 10'd9);
      chk("t1_pcnt", pkt_count, 32'd1);
      idle_check("t1_no_extra", 10);

      reset_n = 1'b0;
      commited_wr_address = '0;
      cycles(2);
      reset_n = 1'b1;
      cycles(2);
      put_pkt(0, 61, 2);
      put_pkt(9, 1, 3);
      commited_wr_address = 10'd11;
      get_pkt(0, 61, 2, 1'b0);
      get_pkt(9, 1, 3, 1'b0);
      cycles(4);
      chk("t2_ext", rd_addr_extended, 10'd11);
      chk("t2_pcnt", pkt_count, 32'd2);

      put_pkt(11, 1500, 4);
      commited_wr_address = 10'd200;
      get_pkt(11, 1500, 4, 1'b1);
      cycles(4);
      chk("t3_ext", rd_addr_extended, 10'd200);
      chk("t3_pcnt", pkt_count, 32'd3);

      put_hdr(200, 0);
      commited_wr_address = 10'd205;
      idle_check("t5_no_beats", 20);
      chk("t5_ext", rd_addr_extended, 10'd205);
      chk("t5_ccnt", corrupt_count, 16'd1);
      chk("t5_pcnt", pkt_count, 32'd3);

      put_hdr(205, 0);
      commited_wr_address = 10'd508;
      cycles(12);
      chk("skip_ext", rd_addr_extended, 10'd508);
      chk("skip_ccnt", corrupt_count, 16'd2);

      put_pkt(508, 80, 5);
      commited_wr_address = 10'd519;
      get_pkt(508, 80, 5, 1'b0);
      cycles(4);
      chk("t4_ext", rd_addr_extended, 10'd519);
      chk("t4_pcnt", pkt_count, 32'd4);

      put_hdr(519, 64);
      commited_wr_address = 10'd522;
      idle_check("ovr_no_beats", 15);
      chk("ovr_ext", rd_addr_extended, 10'd522);
      chk("ovr_ccnt", corrupt_count, 16'd3);

      enable = 1'b0;
      put_pkt(522, 16, 6);
      commited_wr_address = 10'd525;
      idle_check("en_off_idle", 20);
      chk("en_off_ext", rd_addr_extended, 10'd522);
      enable = 1'b1;
      get_pkt(522, 16, 6, 1'b0);
      cycles(4);
      chk("en_on_ext", rd_addr_extended, 10'd525);
      chk("en_on_pcnt", pkt_count, 32'd5);

      put_pkt(525, 24, 7);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         commited_wr_address = (i % 2 == 1) ? 10'd529 : 10'd525;
         if (pkt_valid) seen = 1'b1;
      end
      chk("cdc_no_start", seen, 1'b0);
      chk("cdc_ext", rd_addr_extended, 10'd525);
      commited_wr_address = 10'd529;
      get_pkt(525, 24, 7, 1'b0);
      cycles(4);
      chk("cdc_ext2", rd_addr_extended, 10'd529);

      put_pkt(529, 400, 8);
      commited_wr_address = 10'd580;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (pkt_valid) seen = 1'b1;
      end
      chk("rst_mid_seen", seen, 1'b1);
      cycles(5);
      reset_n = 1'b0;
      commited_wr_address = '0;
      #1;
      chk("rst_mid_valid", pkt_valid, 1'b0);
      chk("rst_mid_ext", rd_addr_extended, 10'd0);
      chk("rst_mid_pcnt", pkt_count, 32'd0);
      cycles(2);
      reset_n = 1'b1;
      idle_check("rst_mid_idle", 10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
